// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: memory-mapped UART controller. Buffers CPU bytes in a TX FIFO and
// launches the TX engine one frame at a time, buffers received bytes in an RX FIFO,
// keeps sticky error flags and drives a registered level interrupt.
module uart_bus_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Addr,
  input  logic        WE,
  input  logic        RE,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_parity_err,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE} tx_state_t;

  logic [7:0]       r_tx_mem [FIFO_DEPTH];
  logic [7:0]       r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
  logic             r_rx_ovr, r_par_err, r_tx_ovf;
  logic             r_rx_ie, r_err_ie, r_irq;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  tx_state_t        r_state;

  logic w_tx_wr, w_ctrl_wr, w_rx_rd, w_clr, w_flush;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_tx_drop;
  logic w_rx_push, w_rx_pop, w_rx_drop;
  logic [31:0] w_status;
  logic w_unused_wdata;

  assign w_tx_wr    = WE && (Addr == 4'h0);
  assign w_ctrl_wr  = WE && (Addr == 4'hC);
  assign w_rx_rd    = RE && (Addr == 4'h4);
  assign w_clr      = w_ctrl_wr && WData[0];
  assign w_flush    = w_ctrl_wr && WData[1];

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);

  // The sequencer only takes the head while idle and the engine is free; a flush
  // in the same cycle empties the FIFO instead of launching its head.
  assign w_tx_pop   = (r_state == S_IDLE) && !w_tx_empty && !tx_busy && !w_flush;
  assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop);
  assign w_tx_drop  = w_tx_wr && w_tx_full && !w_tx_pop;

  assign w_rx_pop   = w_rx_rd && !w_rx_empty;
  assign w_rx_push  = rx_valid && (!w_rx_full || w_rx_pop) && !w_flush;
  assign w_rx_drop  = rx_valid && w_rx_full && !w_rx_pop && !w_flush;

  assign w_unused_wdata = ^WData[31:8];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= WData[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else if (w_flush) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      r_tx_cnt <= r_tx_cnt + CNT_W'(w_tx_push) - CNT_W'(w_tx_pop);
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else if (w_flush) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      r_rx_cnt <= r_rx_cnt + CNT_W'(w_rx_push) - CNT_W'(w_rx_pop);
    end
  end

  // Sticky error flags; a clear request overrides any set in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_ovr  <= 1'b0;
      r_par_err <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else if (w_clr) begin
      r_rx_ovr  <= 1'b0;
      r_par_err <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else begin
      if (w_rx_drop)                  r_rx_ovr  <= 1'b1;
      if (rx_valid && rx_parity_err)  r_par_err <= 1'b1;
      if (w_tx_drop)                  r_tx_ovf  <= 1'b1;
    end
  end

  // Interrupt enables plus the registered interrupt level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_ie  <= 1'b0;
      r_err_ie <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_rx_ie  <= WData[2];
        r_err_ie <= WData[3];
      end
      r_irq <= (r_rx_ie && !w_rx_empty) || (r_err_ie && (r_rx_ovr || r_par_err || r_tx_ovf));
    end
  end

  // TX sequencer: load byte, pulse start for one cycle, wait for the engine's busy window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_tx_data  <= r_tx_mem[r_tx_rd];
            r_tx_start <= 1'b1;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tx_start <= 1'b0;
          r_state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!tx_busy) r_state <= S_IDLE;
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // STATUS word assembly
  always_comb begin
    w_status              = '0;
    w_status[0]           = w_tx_full;
    w_status[1]           = w_tx_empty;
    w_status[2]           = !w_rx_empty;
    w_status[3]           = w_rx_full;
    w_status[4]           = r_rx_ovr;
    w_status[5]           = r_par_err;
    w_status[6]           = r_tx_ovf;
    w_status[7]           = (r_state == S_IDLE) && w_tx_empty;
    w_status[8 +: CNT_W]  = r_tx_cnt;
    w_status[12 +: CNT_W] = r_rx_cnt;
  end

  // Read mux, combinational from the offset and current state
  always_comb begin
    RData = '0;
    case (Addr)
      4'h4:    RData = w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rd]};
      4'h8:    RData = w_status;
      4'hC:    RData = {28'h0, r_err_ie, r_rx_ie, 2'b00};
      default: RData = '0;
    endcase
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign irq      = r_irq;

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: scoreboard bench for uart_bus_ctrl with a TX engine model,
// a transaction-level FIFO/flag model and randomized bus/RX traffic.
`timescale 1ns/1ps
module tb_uart_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  Addr = 4'h0;
  logic        WE = 1'b0;
  logic        RE = 1'b0;
  logic [31:0] WData = 32'h0;
  logic [31:0] RData;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_parity_err = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboard queues
  logic [7:0]  tx_exp[$];
  string       rd_name_q[$];
  logic [31:0] rd_val_q[$];

  // Reference model state
  logic [7:0] m_rx_q[$];
  int         m_tx_cnt = 0;
  bit         m_ovr = 0, m_par = 0, m_ovf = 0, m_rx_ie = 0, m_err_ie = 0;

  // TX engine model controls
  int eng_len   = 10;
  bit hold_busy = 0;
  int eng_cnt   = 0;
  bit prev_start = 0;

  uart_bus_ctrl #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .WE(WE), .RE(RE), .WData(WData), .RData(RData),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int rc;
    rc = m_rx_q.size();
    return 32'(m_tx_cnt == 4) | (32'(m_tx_cnt == 0) << 1) | (32'(rc != 0) << 2) |
           (32'(rc == 4) << 3) | (32'(m_ovr) << 4) | (32'(m_par) << 5) | (32'(m_ovf) << 6) |
           (32'(m_tx_cnt == 0) << 7) | (32'(m_tx_cnt) << 8) | (32'(rc) << 12);
  endfunction

  function automatic bit exp_irq();
    return (m_rx_ie && m_rx_q.size() != 0) || (m_err_ie && (m_ovr || m_par || m_ovf));
  endfunction

  task automatic model_reset();
    m_rx_q.delete();
    m_tx_cnt = 0;
    m_ovr = 0; m_par = 0; m_ovf = 0; m_rx_ie = 0; m_err_ie = 0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // One bus/RX cycle: queue the expected read data, advance the model, then check irq
  task automatic bus(input bit we, input bit re, input logic [3:0] a, input logic [31:0] wd,
                     input bit rxv, input logic [7:0] rxd, input bit perr);
    logic [31:0] e_rd;
    bit e_irq, flush, clr;
    e_irq = exp_irq();
    Addr = a; WE = we; RE = re; WData = wd;
    rx_valid = rxv; rx_data = rxd; rx_parity_err = perr;
    if (re) begin
      case (a)
        4'h4:    e_rd = (m_rx_q.size() != 0) ? {24'h0, m_rx_q[0]} : 32'h0;
        4'h8:    e_rd = exp_status();
        4'hC:    e_rd = {28'h0, m_err_ie, m_rx_ie, 2'b00};
        default: e_rd = 32'h0;
      endcase
      rd_name_q.push_back($sformatf("read_0x%0h", a));
      rd_val_q.push_back(e_rd);
    end
    flush = we && (a == 4'hC) && wd[1];
    clr   = we && (a == 4'hC) && wd[0];
    if (re && a == 4'h4 && m_rx_q.size() != 0) void'(m_rx_q.pop_front());
    if (rxv) begin
      if (perr) m_par = 1;
      if (!flush) begin
        if (m_rx_q.size() < 4) m_rx_q.push_back(rxd);
        else m_ovr = 1;
      end
    end
    if (we && a == 4'h0) begin
      if (m_tx_cnt < 4) begin
        m_tx_cnt++;
        tx_exp.push_back(wd[7:0]);
      end else m_ovf = 1;
    end
    if (we && a == 4'hC) begin
      m_rx_ie = wd[2];
      m_err_ie = wd[3];
    end
    if (clr) begin m_ovr = 0; m_par = 0; m_ovf = 0; end
    if (flush) begin m_rx_q.delete(); m_tx_cnt = 0; end
    @(posedge clk); #1;
    WE = 0; RE = 0; rx_valid = 0; rx_parity_err = 0;
    check("irq", 32'(irq), 32'(e_irq));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus(1, 0, a, d, 0, 8'h00, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    bus(0, 1, a, 32'h0, 0, 8'h00, 0);
  endtask

  task automatic rxp(input logic [7:0] d, input bit perr);
    bus(0, 0, 4'h0, 32'h0, 1, d, perr);
  endtask

  // Wait (bounded) until every queued byte has been launched and the engine is idle
  task automatic drain(input string name);
    int t;
    t = 0;
    while ((tx_exp.size() != 0 || tx_busy) && t < 600) begin
      cycle();
      t++;
    end
    repeat (3) cycle();
    check(name, 32'(tx_exp.size()), 32'h0);
    check({name, "_busy"}, 32'(tx_busy), 32'h0);
    m_tx_cnt = 0;
  endtask

  // TX engine model: busy for eng_len cycles after each launch pulse
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst) eng_cnt = 0;
      else begin
        if (eng_cnt > 0) eng_cnt--;
        if (tx_start) eng_cnt = eng_len;
      end
      tx_busy = hold_busy || (eng_cnt > 0);
    end
  end

  // TX monitor: every launch must carry the next accepted byte, as a one-cycle pulse
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        check("tx_start_width", 32'(prev_start), 32'h0);
        if (tx_exp.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL tx_unexpected: launch of 0x%02h, expected no launch", tx_data);
        end else check("tx_data", 32'(tx_data), 32'(tx_exp.pop_front()));
      end
      prev_start = (tx_start === 1'b1);
    end
  end

  // Read monitor: compare RData during every read strobe
  initial begin
    forever begin
      @(negedge clk);
      if (RE === 1'b1) begin
        if (rd_val_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL read_unexpected: RData 0x%08h, expected no read", RData);
        end else check(rd_name_q.pop_front(), RData, rd_val_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time 1ms reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k, op;
    logic [3:0] a;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_start", 32'(tx_start), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst = 1'b1;
    model_reset();
    rd(4'h8);
    rd(4'hC);

    // Two frames through an idle path, with launch latency
    eng_len = 10;
    wr(4'h0, 32'h55);
    check("tx_start_early", 32'(tx_start), 32'h0);
    wr(4'h0, 32'hAA);
    check("tx_latency", 32'(tx_start), 32'h1);
    drain("t1_drain");
    rd(4'h8);

    // Overflow while the engine is busy, then release
    hold_busy = 1;
    cycle();
    for (int i = 0; i < 5; i++) wr(4'h0, 32'hA1 + 32'(i));
    rd(4'h8);
    hold_busy = 0;
    drain("t2_drain");
    rd(4'h8);
    wr(4'hC, 32'h3);

    // RX ordering and empty read
    rxp(8'h0C, 0);
    rxp(8'h08, 0);
    rd(4'h4); rd(4'h4); rd(4'h4);
    rd(4'h8);

    // RX overrun, then simultaneous push and pop at full
    for (int i = 0; i < 5; i++) rxp(8'h40 + 8'(i), 0);
    rd(4'h8);
    bus(0, 1, 4'h4, 32'h0, 1, 8'h99, 0);
    rd(4'h8);
    for (int i = 0; i < 4; i++) rd(4'h4);
    wr(4'hC, 32'h3);

    // Interrupt on parity error, clear, and read-out
    wr(4'hC, 32'hC);
    rxp(8'h3C, 1);
    cycle();
    check("t5_irq_set", 32'(irq), 32'h1);
    wr(4'hC, 32'hD);
    cycle();
    check("t5_irq_rx_avail", 32'(irq), 32'h1);
    rd(4'h4);
    cycle();
    check("t5_irq_clear", 32'(irq), 32'h0);
    wr(4'hC, 32'h3);

    // Randomized TX bursts against a held engine
    for (int r = 0; r < 5; r++) begin
      hold_busy = 1;
      cycle();
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) wr(4'h0, $urandom);
      rd(4'h8);
      hold_busy = 0;
      eng_len = $urandom_range(3, 8);
      drain("rand_tx_drain");
      rd(4'h8);
      wr(4'hC, {28'h0, 2'($urandom), 2'b01});
    end

    // Randomized RX, register and unmapped traffic
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: rxp(8'($urandom), ($urandom_range(0, 7) == 0));
        3, 4:    rd(4'h4);
        5:       rd(4'h8);
        6:       bus(0, 1, 4'h4, 32'h0, 1, 8'($urandom), ($urandom_range(0, 7) == 0));
        7:       bus(1, 0, 4'hC, $urandom, $urandom_range(0, 1) == 1, 8'($urandom),
                     ($urandom_range(0, 3) == 0));
        8: begin
          a = 4'($urandom_range(1, 11));
          wr(a, $urandom);
        end
        default: begin
          a = 4'($urandom_range(0, 15));
          rd(a);
        end
      endcase
    end
    rd(4'h8);

    // Asynchronous reset in the middle of a frame
    wr(4'hC, 32'h3);
    wr(4'hC, 32'h4);
    eng_len = 40;
    wr(4'h0, 32'h11);
    wr(4'h0, 32'h22);
    rxp(8'h33, 0);
    k = 0;
    while (tx_exp.size() > 1 && k < 20) begin cycle(); k++; end
    check("t6_first_launch", 32'(tx_exp.size()), 32'h1);
    repeat (6) cycle();
    check("t6_irq_before", 32'(irq), 32'h1);
    #3;
    rst = 1'b0;
    #1;
    check("t6_tx_start", 32'(tx_start), 32'h0);
    check("t6_tx_data", 32'(tx_data), 32'h0);
    check("t6_irq", 32'(irq), 32'h0);
    Addr = 4'h8;
    #1;
    check("t6_status", RData, 32'h0000_0082);
    tx_exp.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    rd(4'h8);
    eng_len = 5;
    wr(4'h0, 32'h5A);
    drain("t6_post_drain");
    rd(4'h8);
    cycle();
    check("rd_queue_empty", 32'(rd_val_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
